axi4_frame_push: RTL and testbench

AXI4 write master that drives the slave write port of axi4_frame_fetch. It takes a stream of 256-bit pixel groups (pixel-group source, one frame = FRAME_PG_NUM groups) and packs them into fixed-length INCR write bursts. It issues one burst at a time and tracks the frame position. Sits upstream of axi4_frame_fetch in SOC.

---
 rtl/axi4_frame_push_pkg.sv | 23 ++
 rtl/axi4_frame_push_if.sv | 46 ++++
 rtl/axi4_frame_push_addr_gen.sv | 43 ++++
 rtl/axi4_frame_push.sv | 137 +++++++++++++
 tb/tb_axi4_frame_push.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_frame_push_pkg.sv
// Shared encodings, defaults and FSM state type for the frame push write master.
package axi4_frame_push_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int FRAME_PG_NUM_DEF = 3600;
  localparam int DATA_WIDTH_DEF   = 256;
  localparam int BYTES_PER_BEAT   = DATA_WIDTH_DEF / 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP
  } push_state_e;

  // AxSIZE encoding: log2 of bytes per beat.
  function automatic int axsize_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_frame_push_if.sv
// AXI4 write-only channel bundle (AW/W/B) between the frame push master and its slave.
interface axi4_frame_push_if #(
  parameter int MST_ID_W          = 3,
  parameter int DATA_WIDTH        = 256,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_BURST_W     = 2,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2
);

  logic [MST_ID_W-1:0]          awid;
  logic [ADDR_WIDTH-1:0]        awaddr;
  logic [TRANS_DATA_LEN_W-1:0]  awlen;
  logic [TRANS_DATA_SIZE_W-1:0] awsize;
  logic [TRANS_BURST_W-1:0]     awburst;
  logic                         awvalid;
  logic                         awready;

  logic [DATA_WIDTH-1:0]        wdata;
  logic                         wlast;
  logic                         wvalid;
  logic                         wready;

  logic [MST_ID_W-1:0]          bid;
  logic [TRANS_WR_RESP_W-1:0]   bresp;
  logic                         bvalid;
  logic                         bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wlast, wvalid,
    output bready,
    input  awready, wready,
    input  bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wlast, wvalid,
    input  bready,
    output awready, wready,
    output bid, bresp, bvalid
  );

endinterface

// File: rtl/axi4_frame_push_addr_gen.sv
// Burst start address and in-frame burst counter; wraps to the frame base and
// pulses frame_done once the last burst of a frame has been responded.
module axi4_frame_push_addr_gen #(
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR        = '0,
  parameter int                    BURST_BYTES      = 128,
  parameter int                    BURSTS_PER_FRAME = 900
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  frame_done
);

  localparam int CNT_W = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0]      LAST_BURST = CNT_W'(BURSTS_PER_FRAME - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP  = ADDR_WIDTH'(BURST_BYTES);

  logic [CNT_W-1:0] burst_cnt;

  // Address adds wrap modulo 2^ADDR_WIDTH by construction.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr       <= BASE_ADDR;
      burst_cnt  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (step) begin
        if (burst_cnt == LAST_BURST) begin
          addr       <= BASE_ADDR;
          burst_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          addr      <= addr + ADDR_STEP;
          burst_cnt <= burst_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/axi4_frame_push.sv
// AXI4 write master packing pixel groups into fixed-length INCR bursts, one outstanding.
// Optional FRAME_PUSH_RESP_CHK_EN enables the sticky BRESP/BID error flag.
module axi4_frame_push
  import axi4_frame_push_pkg::*;
#(
  parameter int                    MST_ID_W          = 3,
  parameter int                    MST_ID            = 0,
  parameter int                    DATA_WIDTH        = DATA_WIDTH_DEF,
  parameter int                    ADDR_WIDTH        = 32,
  parameter int                    TRANS_BURST_W     = 2,
  parameter int                    TRANS_DATA_LEN_W  = 3,
  parameter int                    TRANS_DATA_SIZE_W = 3,
  parameter int                    TRANS_WR_RESP_W   = 2,
  parameter int                    BURST_LEN         = 4,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR         = '0,
  parameter int                    FRAME_PG_NUM      = FRAME_PG_NUM_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pg_data_i,
  input  logic                  pg_valid_i,
  output logic                  pg_ready_o,
  axi4_frame_push_if.master     bus,
  output logic                  frame_done_o,
  output logic                  resp_err_o
);

  localparam int BEAT_W           = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int BURST_BYTES      = BURST_LEN * (DATA_WIDTH / 8);
  localparam int BURSTS_PER_FRAME = FRAME_PG_NUM / BURST_LEN;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  push_state_e           state;
  logic [BEAT_W-1:0]     beat_cnt;
  logic                  awvalid_q;
  logic                  bready_q;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  in_data;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;

  assign in_data = (state == ST_DATA);
  assign aw_hs   = awvalid_q & bus.awready;
  assign w_hs    = bus.wvalid & bus.wready;
  assign b_hs    = bready_q & bus.bvalid;

  assign bus.awid    = MST_ID_W'(MST_ID);
  assign bus.awaddr  = addr;
  assign bus.awlen   = TRANS_DATA_LEN_W'(BURST_LEN - 1);
  assign bus.awsize  = TRANS_DATA_SIZE_W'(axsize_of(DATA_WIDTH));
  assign bus.awburst = TRANS_BURST_W'(AXI_BURST_INCR);
  assign bus.awvalid = awvalid_q;
  assign bus.bready  = bready_q;

  // The pixel stream is wired straight onto W while a burst is in its data phase.
  assign bus.wdata  = pg_data_i;
  assign bus.wvalid = in_data & pg_valid_i;
  assign bus.wlast  = in_data & (beat_cnt == LAST_BEAT);
  assign pg_ready_o = in_data & bus.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      awvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pg_valid_i) begin
            awvalid_q <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (aw_hs) begin
            awvalid_q <= 1'b0;
            state     <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            if (bus.wlast) begin
              beat_cnt <= '0;
              bready_q <= 1'b1;
              state    <= ST_RESP;
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        ST_RESP: begin
          if (b_hs) begin
            bready_q <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  axi4_frame_push_addr_gen #(
    .ADDR_WIDTH       (ADDR_WIDTH),
    .BASE_ADDR        (BASE_ADDR),
    .BURST_BYTES      (BURST_BYTES),
    .BURSTS_PER_FRAME (BURSTS_PER_FRAME)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .step       (b_hs),
    .addr       (addr),
    .frame_done (frame_done_o)
  );

`ifdef FRAME_PUSH_RESP_CHK_EN
  logic resp_err_q;

  // Errored bursts are flagged but never retried; the frame keeps advancing.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_err_q <= 1'b0;
    end else if (b_hs && ((bus.bresp != TRANS_WR_RESP_W'(AXI_RESP_OKAY)) ||
                          (bus.bid != MST_ID_W'(MST_ID)))) begin
      resp_err_q <= 1'b1;
    end
  end

  assign resp_err_o = resp_err_q;
`else
  wire unused_bresp = ^{bus.bid, bus.bresp};

  assign resp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_axi4_frame_push.sv
// Directed + randomized bench for axi4_frame_push against a frame-position reference model.
module tb_axi4_frame_push;

  localparam int DW      = 256;
  localparam int AW      = 32;
  localparam int BL      = 4;
  localparam int FPG     = 3600;
  localparam int NBURST  = FPG / BL;
  localparam int BYTES   = BL * DW / 8;
  localparam int MST_ID  = 0;
  localparam logic [AW-1:0] BASE = 32'h0000_0000;
`ifdef FRAME_PUSH_RESP_CHK_EN
  localparam bit RE = 1'b1;
`else
  localparam bit RE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] pg_data = '0;
  logic          pg_valid = 1'b0;
  logic          pg_ready;
  logic          frame_done;
  logic          resp_err;

  axi4_frame_push_if #(
    .MST_ID_W(3), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRANS_BURST_W(2),
    .TRANS_DATA_LEN_W(3), .TRANS_DATA_SIZE_W(3), .TRANS_WR_RESP_W(2)
  ) bus ();

  axi4_frame_push #(
    .MST_ID_W(3), .MST_ID(MST_ID), .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .TRANS_BURST_W(2), .TRANS_DATA_LEN_W(3), .TRANS_DATA_SIZE_W(3),
    .TRANS_WR_RESP_W(2), .BURST_LEN(BL), .BASE_ADDR(BASE), .FRAME_PG_NUM(FPG)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pg_data_i    (pg_data),
    .pg_valid_i   (pg_valid),
    .pg_ready_o   (pg_ready),
    .bus          (bus),
    .frame_done_o (frame_done),
    .resp_err_o   (resp_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slave knobs
  int aw_delay  = 0;
  int w_mode    = 0;
  int err_burst = -1;

  // slave / monitor state
  int   aw_cnt = 0, b_pending = 0, b_total = 0, cyc = 0;
  int   fd_cnt = 0, fd_cyc = -1, b_cyc = -1, dmis = 0, aw_unstable = 0;
  bit   in_data = 0, b_hs_prev = 0, prev_aw_wait = 0;
  logic [AW-1:0] prev_awaddr = '0;

  logic [AW-1:0] aw_addr_q[$];
  logic [10:0]   aw_meta_q[$];
  logic [DW-1:0] w_data_q[$];
  bit            w_last_q[$];

  // reference model
  logic [DW-1:0] exp_data_q[$];
  int k = 0;
  int wpos = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_pg();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Slave responder and channel monitor: drive at negedge, observe 1 time unit later.
  initial begin
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bid     = '0;
    bus.bresp   = '0;
    forever begin
      @(negedge clk);
      if (b_hs_prev) begin
        bus.bvalid = 1'b0;
        b_pending--;
      end
      bus.awready = bus.awvalid && (aw_cnt >= aw_delay);
      aw_cnt = bus.awvalid ? aw_cnt + 1 : 0;
      case (w_mode)
        0:       bus.wready = 1'b1;
        1:       bus.wready = !bus.wready;
        default: bus.wready = 1'($urandom_range(0, 1));
      endcase
      if (!bus.bvalid && b_pending > 0) begin
        bus.bvalid = 1'b1;
        bus.bid    = 3'(MST_ID);
        bus.bresp  = (b_total == err_burst) ? 2'b10 : 2'b00;
      end
      #1;
      cyc++;
      if (rst) begin
        in_data = 0; b_pending = 0; b_total = 0; b_hs_prev = 0;
        fd_cnt = 0; prev_aw_wait = 0; bus.bvalid = 1'b0;
      end else begin
        if (prev_aw_wait && (!bus.awvalid || bus.awaddr !== prev_awaddr)) aw_unstable++;
        prev_aw_wait = bus.awvalid && !bus.awready;
        prev_awaddr  = bus.awaddr;
        if (pg_ready !== (in_data && bus.wready)) dmis++;
        if (bus.wvalid !== (in_data && pg_valid)) dmis++;
        if ((pg_valid && pg_ready) !== (bus.wvalid && bus.wready)) dmis++;
        if (bus.wvalid && bus.wready) begin
          w_data_q.push_back(bus.wdata);
          w_last_q.push_back(bus.wlast);
          if (bus.wlast) begin
            in_data = 0;
            b_pending++;
          end
        end
        if (bus.awvalid && bus.awready) begin
          aw_addr_q.push_back(bus.awaddr);
          aw_meta_q.push_back({bus.awid, bus.awlen, bus.awsize, bus.awburst});
          in_data = 1;
        end
        if (bus.bvalid && bus.bready) begin
          b_hs_prev = 1;
          b_total++;
          b_cyc = cyc;
        end else begin
          b_hs_prev = 0;
        end
        if (frame_done) begin
          fd_cnt++;
          fd_cyc = cyc;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_beat(input logic [DW-1:0] d);
    int t;
    exp_data_q.push_back(d);
    pg_data  = d;
    pg_valid = 1'b1;
    t = 0;
    forever begin
      #1;
      if (pg_ready) begin
        @(negedge clk);
        break;
      end
      @(negedge clk);
      t++;
      if (t > 200) begin
        chk("beat_timeout", t, 0);
        break;
      end
    end
  endtask

  task automatic wait_b(input int n);
    int t;
    t = 0;
    while (b_total < n && t < 4000) begin
      @(negedge clk);
      #2;
      t++;
    end
    @(negedge clk);
    #2;
    chk("b_count", b_total, n);
  endtask

  task automatic check_aw();
    logic [AW-1:0] ea;
    ea = BASE + AW'((k % NBURST) * BYTES);
    k++;
    chk("aw_present", aw_addr_q.size() > 0, 1'b1);
    if (aw_addr_q.size() > 0) begin
      chk("awaddr", aw_addr_q.pop_front(), ea);
      chk("aw_fields", aw_meta_q.pop_front(), {3'(MST_ID), 3'(BL - 1), 3'd5, 2'b01});
    end
  endtask

  task automatic check_w(input int n);
    for (int i = 0; i < n; i++) begin
      chk("w_present", w_data_q.size() > 0, 1'b1);
      if (w_data_q.size() > 0 && exp_data_q.size() > 0) begin
        chk("wdata", w_data_q.pop_front(), exp_data_q.pop_front());
        chk("wlast", w_last_q.pop_front(), (wpos % BL) == BL - 1);
      end
      wpos++;
    end
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0);
    chk("rst_bready", bus.bready, 0);
    chk("rst_pg_ready", pg_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_awaddr", bus.awaddr, BASE);
    @(negedge clk);
    rst = 1'b0;

    // single burst, always-ready slave
    aw_delay = 0; w_mode = 0;
    for (int i = 0; i < 4; i++) send_beat(DW'(32'hA0 + i));
    pg_valid = 1'b0;
    wait_b(1);
    check_aw();
    check_w(4);
    chk("no_frame_done", fd_cnt, 0);

    // backpressure on AW and W
    @(negedge clk);
    aw_delay = 5; w_mode = 1;
    for (int i = 0; i < 4; i++) send_beat(rand_pg());
    pg_valid = 1'b0;
    wait_b(2);
    check_aw();
    check_w(4);
    chk("aw_stable", aw_unstable, 0);
    chk("w_channel", dmis, 0);

    // source stall mid-burst; third burst gets an error response
    @(negedge clk);
    aw_delay = 1; w_mode = 0; err_burst = 2;
    send_beat(rand_pg());
    send_beat(rand_pg());
    pg_valid = 1'b0;
    repeat (3) @(negedge clk);
    send_beat(rand_pg());
    send_beat(rand_pg());
    pg_valid = 1'b0;
    wait_b(3);
    check_aw();
    check_w(4);
    chk("stall_w_channel", dmis, 0);
    chk("resp_err_set", resp_err, RE);
    err_burst = -1;

    // reset after beat 2 of the fourth burst
    @(negedge clk);
    send_beat(rand_pg());
    send_beat(rand_pg());
    chk("resp_err_held", resp_err, RE);
    pg_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #2;
    chk("mid_rst_awvalid", bus.awvalid, 0);
    chk("mid_rst_wvalid", bus.wvalid, 0);
    chk("mid_rst_bready", bus.bready, 0);
    chk("mid_rst_pg_ready", pg_ready, 0);
    chk("mid_rst_resp_err", resp_err, 0);
    chk("mid_rst_awaddr", bus.awaddr, BASE);
    check_aw();
    check_w(2);
    rst = 1'b0;
    k = 0;
    wpos = 0;
    exp_data_q.delete();
    w_data_q.delete();
    w_last_q.delete();
    aw_addr_q.delete();
    aw_meta_q.delete();

    // full frame with random W backpressure
    @(negedge clk);
    aw_delay = 2; w_mode = 2;
    for (int i = 0; i < FPG; i++) send_beat(rand_pg());
    pg_valid = 1'b0;
    wait_b(NBURST);
    for (int i = 0; i < NBURST; i++) check_aw();
    check_w(FPG);
    chk("frame_done_cnt", fd_cnt, 1);
    chk("frame_done_time", fd_cyc, b_cyc + 1);
    chk("frame_w_channel", dmis, 0);
    chk("frame_aw_stable", aw_unstable, 0);
    chk("frame_resp_err", resp_err, 0);

    // first burst of the next frame restarts at the base address
    @(negedge clk);
    w_mode = 0; aw_delay = 0;
    for (int i = 0; i < 4; i++) send_beat(rand_pg());
    pg_valid = 1'b0;
    wait_b(NBURST + 1);
    check_aw();
    check_w(4);
    chk("frame_done_single", fd_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
